// File: rtl/circ_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : circ_frame_pkg
// Purpose  : Shared types and constants for the circular frame scheduler.
// Revision : 1.0
// ============================================================================
package circ_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_SEND = 2'd2,
        ST_WRAP = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/circ_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : circ_frame_scheduler_if
// Purpose  : Byte stream valid/ready link from the scheduler to the UART TX.
// Revision : 1.0
// ============================================================================
interface circ_frame_scheduler_if #(
    parameter int WIDTH = 8
);
    import circ_frame_pkg::*;

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/circ_frame_mem.sv
`default_nettype none
// ============================================================================
// Module   : circ_frame_mem
// Purpose  : Frame register array with a rotated tx read port and full view.
// Revision : 1.0
// ============================================================================
module circ_frame_mem
    import circ_frame_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 16,
    parameter int PTR_W = $clog2(SIZE)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [PTR_W-1:0]      wr_idx,
    input  wire logic [WIDTH-1:0]      wr_data,
    input  wire logic [PTR_W-1:0]      rot_idx,
    input  wire logic [PTR_W-1:0]      rd_off,
    output logic      [WIDTH-1:0]      rd_data,
    output logic      [WIDTH*SIZE-1:0] reg_out
);

    localparam logic [PTR_W:0] c_SIZE_EXT = (PTR_W+1)'(SIZE);

    logic [WIDTH-1:0] r_mem [SIZE];

    // Modulo-SIZE add that also holds for non power-of-two frame sizes.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W-1:0] b);
        logic [PTR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_SIZE_EXT) begin
            s = s - c_SIZE_EXT;
        end
        return s[PTR_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_mem[wrap_add(rot_idx, rd_off)];

    for (genvar i = 0; i < SIZE; i++) begin : g_view
        localparam logic [PTR_W-1:0] c_OFF = PTR_W'(i);
        assign reg_out[i*WIDTH +: WIDTH] = r_mem[wrap_add(rot_idx, c_OFF)];
    end

endmodule
`default_nettype wire

// File: rtl/circ_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : circ_frame_scheduler
// Purpose  : Streams a rotating circular frame buffer to UART TX bytes.
//            Optional sync-byte marker: define SCHED_FRAME_MARKER_EN.
// Revision : 1.0
// ============================================================================
module circ_frame_scheduler
    import circ_frame_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int SIZE  = 16,
    localparam int PTR_W = $clog2(SIZE)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [PTR_W-1:0]      wr_idx,
    input  wire logic [WIDTH-1:0]      wr_data,
    input  wire logic                  start,
    input  wire logic                  continuous,
    input  wire logic                  stop,
    circ_frame_scheduler_if.master     tx,
    output logic                       busy,
    output logic                       frame_done,
    output logic      [PTR_W-1:0]      rot_idx,
    output logic      [WIDTH*SIZE-1:0] reg_out
);

    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(SIZE - 1);

    state_t           r_state;
    state_t           w_next;
    logic [PTR_W-1:0] r_idx;
    logic [PTR_W-1:0] r_rot_idx;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_tx_valid;
    logic             r_stop_pend;
    logic             w_hs;
    logic             w_last;
    logic             w_launch;
    logic             w_continue;
    logic [PTR_W-1:0] w_idx_inc;
    logic [PTR_W-1:0] w_rd_off;
    logic [WIDTH-1:0] w_mem_rd;
    logic [WIDTH-1:0] w_launch_data;

`ifdef SCHED_FRAME_MARKER_EN
    localparam logic [WIDTH-1:0] c_SYNC  = WIDTH'(SYNC_BYTE);
    localparam state_t           c_FIRST = ST_MARK;
    assign w_launch_data = c_SYNC;
`else
    localparam state_t           c_FIRST = ST_SEND;
    assign w_launch_data = w_mem_rd;
`endif

    circ_frame_mem #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rot_idx (r_rot_idx),
        .rd_off  (w_rd_off),
        .rd_data (w_mem_rd),
        .reg_out (reg_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)          w_next = c_FIRST;
            ST_MARK: if (w_hs)           w_next = ST_SEND;
            ST_SEND: if (w_last)         w_next = ST_WRAP;
            ST_WRAP: w_next = w_continue ? c_FIRST : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // A stop arriving in the WRAP cycle itself still ends continuous mode here.
    always_comb begin
        busy       = (r_state != ST_IDLE);
        frame_done = (r_state == ST_WRAP);
        w_hs       = r_tx_valid && tx.tx_ready;
        w_last     = (r_state == ST_SEND) && w_hs && (r_idx == c_LAST);
        w_continue = continuous && !(r_stop_pend || stop);
        w_launch   = ((r_state == ST_IDLE) && start) ||
                     ((r_state == ST_WRAP) && w_continue);
        w_idx_inc  = r_idx + PTR_W'(1);
        w_rd_off   = ((r_state == ST_SEND) && w_hs) ? w_idx_inc : r_idx;
    end

    // tx_data is captured from the pre-write memory contents on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_rot_idx   <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            if (w_next == ST_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (stop) begin
                r_stop_pend <= 1'b1;
            end

            if (w_launch) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_launch_data;
                r_idx      <= '0;
            end else if (w_hs && (r_state == ST_MARK)) begin
                r_tx_data  <= w_mem_rd;
            end else if (w_last) begin
                r_tx_valid <= 1'b0;
                r_idx      <= '0;
                r_rot_idx  <= (r_rot_idx == c_LAST) ? '0 : r_rot_idx + PTR_W'(1);
            end else if (w_hs && (r_state == ST_SEND)) begin
                r_idx      <= w_idx_inc;
                r_tx_data  <= w_mem_rd;
            end
        end
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign rot_idx     = r_rot_idx;

endmodule
`default_nettype wire

// File: tb/tb_circ_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_circ_frame_scheduler
// Purpose  : Scoreboard bench for circ_frame_scheduler (SIZE=16, WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_circ_frame_scheduler;

`ifdef SCHED_FRAME_MARKER_EN
    localparam int FRAME_LEN = 18;
`else
    localparam int FRAME_LEN = 17;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [3:0]   wr_idx = '0;
    logic [7:0]   wr_data = '0;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic         stop = 1'b0;
    logic         busy;
    logic         frame_done;
    logic [3:0]   rot_idx;
    logic [127:0] reg_out;

    circ_frame_scheduler_if #(.WIDTH(8)) tx_if ();

    circ_frame_scheduler #(.WIDTH(8), .SIZE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .start      (start),
        .continuous (continuous),
        .stop       (stop),
        .tx         (tx_if),
        .busy       (busy),
        .frame_done (frame_done),
        .rot_idx    (rot_idx),
        .reg_out    (reg_out)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         fd_count = 0;
    int         rot = 0;
    logic [7:0] model [16];
    logic [7:0] exp_q [$];
    logic [3:0] rot_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] view(input int r);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = model[(r + i) % 16];
        return v;
    endfunction

    task automatic push_bytes(input int r, input int n);
`ifdef SCHED_FRAME_MARKER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int i = 0; i < n; i++) exp_q.push_back(model[(r + i) % 16]);
    endtask

    task automatic push_frame();
        logic [31:0] nr;
        push_bytes(rot, 16);
        rot = (rot + 1) % 16;
        nr  = rot;
        rot_q.push_back(nr[3:0]);
    endtask

    // Monitor: every accepted byte and every frame_done pulse is scored.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        logic [3:0] er;
        if (!rst) begin
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_byte: got %0h expected none", tx_if.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_if.tx_data, e);
                end
            end
            if (frame_done) begin
                fd_count++;
                check("valid_low_in_wrap", tx_if.tx_valid, 0);
                if (rot_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done: got pulse expected none");
                end else begin
                    er = rot_q.pop_front();
                    check("rot_after_frame", rot_idx, er);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame();
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 0;
        pulse_start();
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            cnt++;
            if (frame_done) done = 1;
        end
        check("frame_len", cnt, FRAME_LEN);
        @(posedge clk); #1;
        check("busy_after_frame", busy, 0);
    endtask

    task automatic wait_for_byte(input logic [7:0] b);
        bit found;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk); #1;
            if (tx_if.tx_valid && tx_if.tx_data == b) found = 1;
        end
        check("reach_byte", found, 1);
    endtask

    task automatic wait_fd(input int target);
        bit done;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk); #1;
            if (fd_count >= target) done = 1;
        end
        check("frame_done_seen", done, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int fd0;
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tx_valid", tx_if.tx_valid, 0);
        check("rst_tx_data", tx_if.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rot_idx", rot_idx, 0);
        check("rst_reg_out", reg_out, 0);

        // Load mem[i] = i.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_idx = 4'(i); wr_data = 8'(i);
            model[i] = 8'(i);
        end
        @(posedge clk); #1 wr_en = 1'b0;
        check("reg_out_loaded", reg_out, view(0));

        tx_if.tx_ready = 1'b1;
        push_frame();
        run_frame();
        check("rot_idx_1", rot_idx, 1);

        push_frame();
        run_frame();
        check("rot_idx_2", rot_idx, 2);
        check("reg_out_slice0", reg_out[7:0], 8'h02);
        check("reg_out_rot2", reg_out, view(2));

        // Backpressure on byte 05.
        push_frame();
        pulse_start();
        wait_for_byte(8'h05);
        tx_if.tx_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_valid_held", tx_if.tx_valid, 1);
            check("bp_data_held", tx_if.tx_data, 8'h05);
        end
        tx_if.tx_ready = 1'b1;
        wait_fd(fd_count + 1);
        @(posedge clk); #1;
        check("bp_rot_idx", rot_idx, 3);

        // Continuous mode ended by a stop pulse in frame 2.
        fd0 = fd_count;
        push_frame();
        push_frame();
        continuous = 1'b1;
        pulse_start();
        wait_fd(fd0 + 1);
        repeat (4) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_fd(fd0 + 2);
        repeat (30) @(posedge clk);
        #1;
        check("cont_frame_count", fd_count, fd0 + 2);
        check("cont_idle", busy, 0);
        check("cont_rot_idx", rot_idx, 5);
        continuous = 1'b0;

        // Reset mid-frame at byte 07.
        push_bytes(5, 2);
        pulse_start();
        wait_for_byte(8'h07);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_tx_valid", tx_if.tx_valid, 0);
        check("midrst_rot_idx", rot_idx, 0);
        check("midrst_reg_out", reg_out, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        rot = 0;
        check("midrst_queue_drained", exp_q.size(), 0);
        push_frame();
        run_frame();
        check("post_rst_rot_idx", rot_idx, 1);

        repeat (3) @(posedge clk);
        check("final_bytes_pending", exp_q.size(), 0);
        check("final_frames_pending", rot_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
